// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
// State encoding, default width and iteration-counter sizing.
package div_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        ITER  = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor and produce one quotient bit.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   i_r,
    input  logic             i_q_msb,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_r_next,
    output logic             o_q_bit
);

    logic [WIDTH:0] w_t;
    logic           w_unused;

    // R stays below the divisor, so its top bit is always zero and drops out of T.
    assign w_t      = {i_r[WIDTH-1:0], i_q_msb};
    assign w_unused = i_r[WIDTH];

    always_comb begin
        if (w_t >= {1'b0, i_divisor}) begin
            o_r_next = w_t - {1'b0, i_divisor};
            o_q_bit  = 1'b1;
        end else begin
            o_r_next = w_t;
            o_q_bit  = 1'b0;
        end
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative radix-2 restoring divider, 2W/W -> W quotient and W remainder.
// Optional DIV_ZERO_SKIP_EN: a zero dividend finishes straight from CHECK.
//
// state | meaning
// IDLE  | ready for operands
// CHECK | classify divide-by-zero / overflow / normal, load iteration regs
// ITER  | one quotient bit per clock, WIDTH steps
// DONE  | result held until out_ready
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero,
    output logic                 overflow,
    output logic                 busy
);

    localparam int CW = cnt_width(WIDTH);

    state_t               r_state;
    state_t               w_next_state;
    logic [2*WIDTH-1:0]   r_dividend;
    logic [WIDTH-1:0]     r_divisor;
    logic [WIDTH:0]       r_rem;
    logic [WIDTH-1:0]     r_q;
    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_quotient;
    logic [WIDTH-1:0]     r_remainder;
    logic                 r_dbz;
    logic                 r_ovf;

    logic                 w_div_zero;
    logic                 w_hi_ge;
    logic                 w_skip;
    logic                 w_last;
    logic [WIDTH:0]       w_r_next;
    logic                 w_q_bit;

    assign w_div_zero = (r_divisor == '0);
    assign w_hi_ge    = (r_dividend[2*WIDTH-1:WIDTH] >= r_divisor);
    assign w_last     = (r_cnt == CW'(WIDTH - 1));
`ifdef DIV_ZERO_SKIP_EN
    assign w_skip     = (r_dividend == '0);
`else
    assign w_skip     = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_r       (r_rem),
        .i_q_msb   (r_q[WIDTH-1]),
        .i_divisor (r_divisor),
        .o_r_next  (w_r_next),
        .o_q_bit   (w_q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:  if (in_valid) w_next_state = CHECK;
            CHECK: w_next_state = (w_div_zero || w_hi_ge || w_skip) ? DONE : ITER;
            ITER:  if (w_last) w_next_state = DONE;
            DONE:  if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
        busy      = (r_state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_dividend <= dividend;
                        r_divisor  <= divisor;
                    end
                end
                CHECK: begin
                    if (w_div_zero) begin
                        r_dbz       <= 1'b1;
                        r_quotient  <= '1;
                        r_remainder <= r_dividend[WIDTH-1:0];
                    end else if (w_hi_ge) begin
                        r_ovf       <= 1'b1;
                        r_quotient  <= '1;
                        r_remainder <= '0;
                    end else if (w_skip) begin
                        r_quotient  <= '0;
                        r_remainder <= '0;
                    end else begin
                        r_rem <= {1'b0, r_dividend[2*WIDTH-1:WIDTH]};
                        r_q   <= r_dividend[WIDTH-1:0];
                        r_cnt <= '0;
                    end
                end
                ITER: begin
                    r_rem <= w_r_next;
                    r_q   <= {r_q[WIDTH-2:0], w_q_bit};
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_quotient  <= {r_q[WIDTH-2:0], w_q_bit};
                        r_remainder <= w_r_next[WIDTH-1:0];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_dbz <= 1'b0;
                        r_ovf <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=8): directed cases,
// backpressure, mid-operation reset and a random sweep against a model.
module tb_seq_restoring_divider;

`ifdef DIV_ZERO_SKIP_EN
    localparam int ZERO_LAT = 2;
`else
    localparam int ZERO_LAT = 10;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        in_ready, out_valid, div_by_zero, overflow, busy;
    logic [7:0]  quotient, remainder;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        logic       ovf;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    seq_restoring_divider #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] dd, input logic [7:0] dv);
        exp_t e;
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        if (dv == 8'd0) begin
            e.dbz = 1'b1; e.q = 8'hFF; e.r = dd[7:0]; e.lat = 2;
        end else if (dd[15:8] >= dv) begin
            e.ovf = 1'b1; e.q = 8'hFF; e.r = 8'h00; e.lat = 2;
        end else begin
            e.q   = 8'(dd / {8'd0, dv});
            e.r   = 8'(dd % {8'd0, dv});
            e.lat = (dd == 16'd0) ? ZERO_LAT : 10;
        end
        return e;
    endfunction

    task automatic send(input logic [15:0] dd, input logic [7:0] dv);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) chk("in_ready_timeout", in_ready, 1);
        sb.push_back(model(dd, dv));
        in_valid = 1'b1; dividend = dd; divisor = dv;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic receive(input int hold);
        int   lat = 1;
        exp_t e;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        if (sb.size() == 0) begin
            chk("sb_empty", out_valid, 0);
            return;
        end
        e = sb.pop_front();
        chk("out_valid", out_valid, 1);
        chk("latency", lat, e.lat);
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.dbz);
        chk("overflow", overflow, e.ovf);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; dividend = 16'h1234; divisor = 8'h56;
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_quotient", quotient, e.q);
            chk("hold_remainder", remainder, e.r);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("valid_drop", out_valid, 0);
        chk("in_ready_rise", in_ready, 1);
        chk("dbz_clear", div_by_zero, 0);
        chk("ovf_clear", overflow, 0);
    endtask

    initial begin
        logic seen;
        #3;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_flags", {div_by_zero, overflow}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        send(16'd12345, 8'd200);
        chk("busy_in_op", busy, 1);
        receive(5);
        send(16'hFE01, 8'hFF);   receive(0);
        send(16'hFFFF, 8'h01);   receive(0);
        send(16'd500, 8'd0);     receive(0);
        send(16'd0, 8'd9);       receive(0);
        send(16'h00FF, 8'h01);   receive(0);

        // reset during the fourth iteration step
        in_valid = 1'b1; dividend = 16'd2000; divisor = 8'd77;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("busy_before_reset", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_quotient", quotient, 0);
        chk("arst_remainder", remainder, 0);
        chk("arst_flags", {div_by_zero, overflow}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        chk("no_valid_after_reset", seen, 0);
        send(16'd7, 8'd3); receive(0);

        for (int i = 0; i < 2000; i++) begin
            logic [15:0] dd;
            logic [7:0]  dv;
            dv = 8'($urandom_range(1, 255));
            case ($urandom_range(0, 9))
                0: dd = 16'($urandom);
                1: begin dd = 16'($urandom); dv = 8'd0; end
                2: dd = 16'd0;
                default: dd = {8'($urandom_range(0, int'(dv) - 1)), 8'($urandom)};
            endcase
            send(dd, dv);
            receive(0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
